// File: rtl/alu_pkg.sv
// Shared constants and types for the UART ALU packet parser and the
// output stages that later opcodes will reuse.
package alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam int         HDR_LEN = 4;

  typedef enum logic [2:0] {
    HDR,
    ECHO,
    ADD_RX,
    ADD_TX,
    DRAIN
  } state_e;

endpackage

// File: rtl/out_reg.sv
// Single-entry valid/ready output register. Accepts a new word in the same
// cycle the held word leaves, so a continuous stream flows without bubbles.
module out_reg #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH_P-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [WIDTH_P-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  logic               valid_q;
  logic [WIDTH_P-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // NOTE: sequential state uses <= so every register samples pre-edge
  // values, independent of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/packet_parser.sv
// UART ALU packet parser: decodes a 4-byte header, then echoes, sums or
// drains the payload. All output bytes leave through one out_reg stage.
module packet_parser
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P    = 8,
  parameter int OPERAND_WIDTH_P = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    len_err_o
);

  localparam int BYTES_C  = OPERAND_WIDTH_P / DATA_WIDTH_P;
  localparam int IDX_W_C  = (BYTES_C > 1) ? $clog2(BYTES_C) : 1;
  localparam int PUSH_W_C = $clog2(BYTES_C + 1);

  localparam logic [IDX_W_C-1:0]  IDX_LAST_C  = IDX_W_C'(BYTES_C - 1);
  localparam logic [PUSH_W_C-1:0] PUSH_LAST_C = PUSH_W_C'(BYTES_C);
  localparam logic [15:0]         HDR_LEN_C   = 16'(HDR_LEN);

  state_e                     state_q, state_d;
  logic [1:0]                 hdr_cnt_q, hdr_cnt_d;
  logic [DATA_WIDTH_P-1:0]    opcode_q, opcode_d;
  logic [7:0]                 len_lsb_q, len_lsb_d;
  logic [15:0]                remain_q, remain_d;
  logic [OPERAND_WIDTH_P-1:0] opnd_q, opnd_d;
  logic [OPERAND_WIDTH_P-1:0] acc_q, acc_d;
  logic [IDX_W_C-1:0]         byte_idx_q, byte_idx_d;
  logic [PUSH_W_C-1:0]        push_cnt_q, push_cnt_d;
  logic                       len_err_q, len_err_d;

  logic                       s_fire;
  logic                       hdr_last;
  logic                       pay_last;
  logic                       op_done;
  logic                       is_echo;
  logic                       is_add;
  logic [15:0]                hdr_len;
  logic [OPERAND_WIDTH_P-1:0] opnd_next;

  logic                       push_valid;
  logic                       push_ready;
  logic [DATA_WIDTH_P-1:0]    push_data;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign hdr_len  = {s_axis_tdata[7:0], len_lsb_q};
  assign hdr_last = (state_q == HDR) && s_fire && (hdr_cnt_q == 2'd3);
  assign pay_last = s_fire && (remain_q == 16'd1);
  assign op_done  = (state_q == ADD_RX) && s_fire && (byte_idx_q == IDX_LAST_C);
  assign is_echo  = (opcode_q == DATA_WIDTH_P'(OP_ECHO));
  assign is_add   = (opcode_q == DATA_WIDTH_P'(OP_ADD));
  assign len_err_o = len_err_q;

  // Operands arrive little-endian: each new byte enters at the top.
  assign opnd_next = (opnd_q >> DATA_WIDTH_P)
                   | (OPERAND_WIDTH_P'(s_axis_tdata) << (OPERAND_WIDTH_P - DATA_WIDTH_P));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR: begin
        if (hdr_last) begin
          if (hdr_len < HDR_LEN_C)       state_d = HDR;
          else if (hdr_len == HDR_LEN_C) state_d = is_add ? ADD_TX : HDR;
          else if (is_echo)              state_d = ECHO;
          else if (is_add)               state_d = ADD_RX;
          else                           state_d = DRAIN;
        end
      end
      ECHO, DRAIN: if (pay_last) state_d = HDR;
      ADD_RX:      if (pay_last) state_d = ADD_TX;
      ADD_TX:      if ((push_cnt_q == PUSH_LAST_C) && push_ready) state_d = HDR;
      default:     state_d = HDR;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    push_valid    = 1'b0;
    push_data     = '0;
    unique case (state_q)
      HDR, ADD_RX, DRAIN: s_axis_tready = 1'b1;
      ECHO: begin
        s_axis_tready = push_ready;
        push_valid    = s_axis_tvalid;
        push_data     = s_axis_tdata;
      end
      ADD_TX: begin
        push_valid = (push_cnt_q != PUSH_LAST_C);
        push_data  = DATA_WIDTH_P'(acc_q >> (push_cnt_q * DATA_WIDTH_P));
      end
      default: s_axis_tready = 1'b0;
    endcase
    if (rst) s_axis_tready = 1'b0;
  end

  always_comb begin
    hdr_cnt_d  = hdr_cnt_q;
    opcode_d   = opcode_q;
    len_lsb_d  = len_lsb_q;
    remain_d   = remain_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    byte_idx_d = byte_idx_q;
    push_cnt_d = push_cnt_q;
    len_err_d  = 1'b0;

    if ((state_q == HDR) && s_fire) begin
      hdr_cnt_d = hdr_cnt_q + 2'd1;
      if (hdr_cnt_q == 2'd0) opcode_d  = s_axis_tdata;
      if (hdr_cnt_q == 2'd2) len_lsb_d = s_axis_tdata[7:0];
      if (hdr_last) begin
        remain_d   = hdr_len - HDR_LEN_C;
        opnd_d     = '0;
        acc_d      = '0;
        byte_idx_d = '0;
        push_cnt_d = '0;
        len_err_d  = (hdr_len < HDR_LEN_C);
      end
    end

    if ((state_q inside {ECHO, ADD_RX, DRAIN}) && s_fire) remain_d = remain_q - 16'd1;

    if ((state_q == ADD_RX) && s_fire) begin
      if (op_done) begin
        acc_d      = acc_q + opnd_next;
        opnd_d     = '0;
        byte_idx_d = '0;
      end else begin
        opnd_d     = opnd_next;
        byte_idx_d = byte_idx_q + 1'b1;
      end
      // A trailing partial operand is dropped and flagged on its last byte.
      if (pay_last && !op_done) len_err_d = 1'b1;
    end

    if ((state_q == ADD_TX) && push_valid && push_ready) push_cnt_d = push_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_q  <= '0;
      opcode_q   <= '0;
      len_lsb_q  <= '0;
      remain_q   <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      byte_idx_q <= '0;
      push_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      hdr_cnt_q  <= hdr_cnt_d;
      opcode_q   <= opcode_d;
      len_lsb_q  <= len_lsb_d;
      remain_q   <= remain_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      byte_idx_q <= byte_idx_d;
      push_cnt_q <= push_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  out_reg #(
    .WIDTH_P (DATA_WIDTH_P)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (push_data),
    .in_valid_i  (push_valid),
    .in_ready_o  (push_ready),
    .out_data_o  (m_axis_tdata),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

endmodule

// File: tb/tb_packet_parser.sv
// Directed bench for packet_parser: a table of whole packets with expected
// output bytes and error pulses, plus hand sequences for stalls and reset.
module tb_packet_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       len_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit toggle_en;
  bit hold_low;
  bit stall_mon;
  int stall_seen = 0;
  int stall_viol = 0;
  int hold_viol  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [7:0] out_b[$];
  int         out_c[$];
  int         err_c[$];
  int         acc_c[$];

  typedef struct {
    string        name;
    int           n_in;
    logic [127:0] in_v;   // bytes right-aligned, first byte most significant
    int           n_exp;
    logic [63:0]  exp_v;
    int           exp_err;
    bit           lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  packet_parser dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .len_err_o     (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (toggle_en) m_tready = !m_tready;
    else           m_tready = !hold_low;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) hold_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (m_tvalid && m_tready) begin
        out_b.push_back(m_tdata);
        out_c.push_back(cyc);
      end
      if (len_err) err_c.push_back(cyc);
      if (stall_mon && m_tvalid && !m_tready) begin
        stall_seen++;
        if (s_tready) stall_viol++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    out_b.delete();
    out_c.delete();
    err_c.delete();
    acc_c.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end else begin
      acc_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic wait_out(input int n);
    int guard = 0;
    while (out_b.size() < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_at(input int k);
    return (k < out_b.size()) ? {24'h0, out_b[k]} : 32'hxxxxxxxx;
  endfunction

  initial begin
    vecs[0]  = '{"echo3",     7,  128'hEC00070011_2233,            3, 64'h112233,   0, 1'b1};
    vecs[1]  = '{"add_wrap",  12, 128'hAD000C00_01000000_FFFFFFFF, 4, 64'h00000000, 0, 1'b0};
    vecs[2]  = '{"add_part",  10, 128'hAD000A00_05000000_AABB,     4, 64'h05000000, 1, 1'b0};
    vecs[3]  = '{"short",     4,  128'hEC000200,                   0, 64'h0,        1, 1'b0};
    vecs[4]  = '{"echo_7e",   5,  128'hEC000500_7E,                1, 64'h7E,       0, 1'b1};
    vecs[5]  = '{"unknown",   6,  128'h55000600_AABB,              0, 64'h0,        0, 1'b0};
    vecs[6]  = '{"echo_42",   5,  128'hEC000500_42,                1, 64'h42,       0, 1'b1};
    vecs[7]  = '{"add_len4",  4,  128'hAD000400,                   4, 64'h00000000, 0, 1'b0};
    vecs[8]  = '{"add_two",   12, 128'hAD000C00_78563412_11111111, 4, 64'h89674523, 0, 1'b0};
    vecs[9]  = '{"unk_len4",  4,  128'h33000400,                   0, 64'h0,        0, 1'b0};
    vecs[10] = '{"add_len0",  4,  128'hAD000000,                   0, 64'h0,        1, 1'b0};
    vecs[11] = '{"drain4",    8,  128'h77000800_01020304,          0, 64'h0,        0, 1'b0};

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_s_tready", {31'h0, s_tready}, 32'h0);
    check("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    check("rst_m_tdata",  {24'h0, m_tdata},  32'h0);
    check("rst_len_err",  {31'h0, len_err},  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_s_tready", {31'h0, s_tready}, 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      clear_logs();
      for (int k = 0; k < vecs[i].n_in; k++)
        send_byte(vecs[i].in_v[(vecs[i].n_in - 1 - k) * 8 +: 8]);
      wait_out(vecs[i].n_exp);
      check({vecs[i].name, "_count"}, out_b.size(), vecs[i].n_exp);
      for (int k = 0; k < vecs[i].n_exp; k++)
        check($sformatf("%s_byte%0d", vecs[i].name, k), out_at(k),
              {24'h0, vecs[i].exp_v[(vecs[i].n_exp - 1 - k) * 8 +: 8]});
      check({vecs[i].name, "_errs"}, err_c.size(), vecs[i].exp_err);
      if (vecs[i].exp_err == 1)
        check({vecs[i].name, "_err_cyc"}, (err_c.size() > 0) ? err_c[0] : -1,
              acc_c[vecs[i].n_in - 1] + 1);
      if (vecs[i].lat)
        for (int k = 0; k < vecs[i].n_exp; k++)
          check($sformatf("%s_lat%0d", vecs[i].name, k),
                (k < out_c.size()) ? out_c[k] : -1, acc_c[4 + k] + 1);
    end

    // Back-to-back echo packets: next opcode accepted right after payload.
    clear_logs();
    send_hdr(8'hEC, 16'd5);
    send_byte(8'hAA);
    send_hdr(8'hEC, 16'd5);
    send_byte(8'hBB);
    wait_out(2);
    check("b2b_count", out_b.size(), 2);
    check("b2b_byte0", out_at(0), 32'hAA);
    check("b2b_byte1", out_at(1), 32'hBB);
    check("b2b_no_gap", acc_c[5], acc_c[4] + 1);

    // 16-byte echo with the transmitter ready toggling every cycle.
    clear_logs();
    toggle_en = 1'b1;
    send_hdr(8'hEC, 16'd20);
    stall_mon = 1'b1;
    for (int k = 0; k < 16; k++) send_byte(8'(k * 7 + 3));
    stall_mon = 1'b0;
    wait_out(16);
    check("tog_count", out_b.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("tog_byte%0d", k), out_at(k), 32'(8'(k * 7 + 3)));
    check("tog_stall_seen", {31'h0, stall_seen > 0}, 32'h1);
    check("tog_ready_low", stall_viol, 0);

    // Add result sent under the same toggling back-pressure.
    clear_logs();
    send_hdr(8'hAD, 16'd8);
    send_byte(8'h04);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_out(4);
    toggle_en = 1'b0;
    check("addtog_count", out_b.size(), 4);
    check("addtog_byte0", out_at(0), 32'h04);
    check("addtog_byte1", out_at(1), 32'h03);
    check("addtog_byte2", out_at(2), 32'h02);
    check("addtog_byte3", out_at(3), 32'h01);

    // Reset in the middle of an add packet.
    clear_logs();
    send_hdr(8'hAD, 16'd12);
    send_byte(8'h01);
    send_byte(8'h02);
    #3 rst = 1'b1;
    #1;
    check("midrst_s_tready", {31'h0, s_tready}, 32'h0);
    check("midrst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_rel_ready", {31'h0, s_tready}, 32'h1);
    @(posedge clk);
    #1;
    send_hdr(8'hEC, 16'd5);
    send_byte(8'h5A);
    wait_out(1);
    check("midrst_count", out_b.size(), 1);
    check("midrst_byte0", out_at(0), 32'h5A);

    // Reset while an echo byte is stuck in the output register.
    clear_logs();
    hold_low = 1'b1;
    @(posedge clk);
    #1;
    send_hdr(8'hEC, 16'd6);
    send_byte(8'h99);
    @(negedge clk);
    check("pend_valid", {31'h0, m_tvalid}, 32'h1);
    check("pend_data",  {24'h0, m_tdata},  32'h99);
    #2 rst = 1'b1;
    #1;
    check("pend_drop_valid", {31'h0, m_tvalid}, 32'h0);
    check("pend_drop_data",  {24'h0, m_tdata},  32'h0);
    hold_low = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    wait_out(0);
    check("pend_none_out", out_b.size(), 0);
    send_hdr(8'hEC, 16'd5);
    send_byte(8'hC3);
    wait_out(1);
    check("pend_next_count", out_b.size(), 1);
    check("pend_next_byte0", out_at(0), 32'hC3);

    check("output_hold", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packet_parser.md
PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 8, meaning stream byte width.
REQ-002 SHALL have parameter OPERAND_WIDTH_P, default 32, meaning adder operand and result width; SHALL be a multiple of DATA_WIDTH_P.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH_P  byte from UART receiver.
REQ-006 SHALL have port s_axis_tvalid  input  1  input byte valid.
REQ-007 SHALL have port s_axis_tready  output  1  parser accepts input byte.
REQ-008 SHALL have port m_axis_tdata  output  DATA_WIDTH_P  byte to UART transmitter.
REQ-009 SHALL have port m_axis_tvalid  output  1  output byte valid.
REQ-010 SHALL have port m_axis_tready  input  1  transmitter accepts output byte.
REQ-011 SHALL have port len_err_o  output  1  one-cycle pulse on malformed length.

Function
REQ-012 An input byte SHALL transfer only when s_axis_tvalid and s_axis_tready are both high on a clock edge; the same rule SHALL apply to output bytes.
REQ-013 Packet SHALL be: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then payload; length SHALL be the 16-bit total including the 4 header bytes.
REQ-014 Opcodes: 0xEC echo, 0xAD add; any other value SHALL be treated as unknown.
REQ-015 FSM states: HDR, ECHO, ADD_RX, ADD_TX, DRAIN; reset state HDR.
REQ-016 HDR: s_axis_tready=1; a 2-bit header counter SHALL advance per accepted byte; on the 4th byte the FSM SHALL choose the next state from the opcode.
REQ-017 Length < 4 SHALL pulse len_err_o for one cycle and return to HDR; no output bytes.
REQ-018 Length == 4: echo and unknown SHALL return to HDR; add SHALL go to ADD_TX with result 0.
REQ-019 ECHO: each payload byte SHALL appear on m_axis_tdata one cycle after acceptance, unmodified and in order; s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register, no bubbles under continuous flow).
REQ-020 ADD_RX: s_axis_tready=1; bytes SHALL assemble little-endian operands of OPERAND_WIDTH_P; each completed operand SHALL add into the accumulator modulo 2^OPERAND_WIDTH_P (carry discarded).
REQ-021 Payload length not a multiple of OPERAND_WIDTH_P/DATA_WIDTH_P: trailing partial operand SHALL be consumed and discarded, and len_err_o SHALL pulse when the last byte is accepted.
REQ-022 ADD_TX: s_axis_tready=0; the accumulator SHALL be sent LSB byte first, OPERAND_WIDTH_P/DATA_WIDTH_P bytes; m_axis_tvalid SHALL stay high and m_axis_tdata stable until accepted; return to HDR after the final byte is accepted.
REQ-023 DRAIN: s_axis_tready=1; remaining payload bytes SHALL be discarded; no output.
REQ-024 A 16-bit remaining-byte counter SHALL load length-4 at header end and decrement per accepted payload byte; the state SHALL exit when it reaches 0.
REQ-025 Accumulator and operand shift register SHALL clear at each header end.
REQ-026 Back-to-back packets SHALL be accepted with no idle cycle between the last payload byte and the next opcode (except behind the ADD_TX wait).

Reset
REQ-027 On rst assertion, state=HDR, all counters, accumulator and operand register=0, m_axis_tvalid=0, m_axis_tdata=0, len_err_o=0, asynchronously.
REQ-028 s_axis_tready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-029 Reset mid-packet SHALL abandon the packet; a pending output byte SHALL be dropped.

Structure
REQ-030 Opcode constants (OP_ECHO, OP_ADD), header length 4 and the FSM state enum SHALL live in shared package alu_pkg.
REQ-031 Output byte register with valid/ready SHALL be one sub-module, out_reg, reusable by later opcodes; everything else SHALL be in packet_parser.

Verification
REQ-032 EC 00 07 00 11 22 33, tready held 1 -> output 11 22 33, each one cycle after acceptance.
REQ-033 AD 00 0C 00 01 00 00 00 FF FF FF FF -> output 00 00 00 00 (wrap), then ready for next header.
REQ-034 AD 00 0A 00 05 00 00 00 AA BB -> output 05 00 00 00, len_err_o pulses once on byte BB.
REQ-035 EC 00 02 00 -> len_err_o pulse, no output; next EC 00 05 00 7E -> output 7E.
REQ-036 Echo of 16 bytes with m_axis_tready toggling 1-0 each cycle -> all 16 bytes in order, none lost or duplicated; s_axis_tready low while output stalled.
REQ-037 Unknown 0x55 00 06 00 AA BB followed by EC 00 05 00 42 -> only 42 output; rst pulsed mid-add packet -> no output, next echo packet correct.
